// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared RISC-V core types and constants
package riscv_pkg;

    localparam int          XLEN        = 32;
    localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;
    localparam int          INSTR_ALIGN = 2;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
        logic            filled;
    } fetch_slot_t;

endpackage

// File: rtl/fetch_buffer.sv
// rtl/fetch_buffer.sv - in-order fetch slot buffer with alloc/fill/read pointers
module fetch_buffer
    import riscv_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             alloc_en,
    input  logic [XLEN-1:0]  alloc_pc,
    input  logic             fill_en,
    input  logic [XLEN-1:0]  fill_instr,
    input  logic             pop_en,
    output logic             head_valid,
    output logic [XLEN-1:0]  head_instr,
    output logic [XLEN-1:0]  head_pc,
    output logic [CNT_W-1:0] count,
    output logic [CNT_W-1:0] pending
);

    fetch_slot_t      slots_q [DEPTH];
    fetch_slot_t      slots_d [DEPTH];
    logic [PTR_W-1:0] alloc_ptr_q, alloc_ptr_d;
    logic [PTR_W-1:0] fill_ptr_q, fill_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] pending_q, pending_d;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Pop clears before alloc so a full buffer can recycle the head slot in one cycle.
    always_comb begin
        slots_d     = slots_q;
        alloc_ptr_d = alloc_ptr_q;
        fill_ptr_d  = fill_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        pending_d   = pending_q;
        if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                slots_d[i].filled = 1'b0;
            end
            alloc_ptr_d = '0;
            fill_ptr_d  = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            pending_d   = '0;
        end else begin
            if (pop_en) begin
                slots_d[rd_ptr_q].filled = 1'b0;
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            if (alloc_en) begin
                slots_d[alloc_ptr_q].pc     = alloc_pc;
                slots_d[alloc_ptr_q].instr  = NOP_INSTR;
                slots_d[alloc_ptr_q].filled = 1'b0;
                alloc_ptr_d = ptr_inc(alloc_ptr_q);
            end
            if (fill_en) begin
                slots_d[fill_ptr_q].instr  = fill_instr;
                slots_d[fill_ptr_q].filled = 1'b1;
                fill_ptr_d = ptr_inc(fill_ptr_q);
            end
            count_d   = count_q + CNT_W'(alloc_en) - CNT_W'(pop_en);
            pending_d = pending_q + CNT_W'(alloc_en) - CNT_W'(fill_en);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                slots_q[i] <= '{pc: '0, instr: NOP_INSTR, filled: 1'b0};
            end
            alloc_ptr_q <= '0;
            fill_ptr_q  <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            pending_q   <= '0;
        end else begin
            slots_q     <= slots_d;
            alloc_ptr_q <= alloc_ptr_d;
            fill_ptr_q  <= fill_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            pending_q   <= pending_d;
        end
    end

    assign head_valid = slots_q[rd_ptr_q].filled;
    assign head_instr = slots_q[rd_ptr_q].instr;
    assign head_pc    = slots_q[rd_ptr_q].pc;
    assign count      = count_q;
    assign pending    = pending_q;

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: PC, request issue, redirect drop, decode handoff
module fetch_unit
    import riscv_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 32'h0000_0000,
    parameter int                    DEPTH      = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  imem_req_valid,
    input  logic                  imem_req_ready,
    output logic [ADDR_WIDTH-1:0] imem_req_addr,
    input  logic                  imem_rsp_valid,
    input  logic [DATA_WIDTH-1:0] imem_rsp_data,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    input  logic                  id_ready,
    output logic                  id_valid,
    output logic [DATA_WIDTH-1:0] id_instr,
    output logic [ADDR_WIDTH-1:0] id_pc,
    output logic [ADDR_WIDTH-1:0] id_pc_plus4
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [ADDR_WIDTH-1:0] last_pc_q, last_pc_d;
    logic [CNT_W-1:0]      drop_cnt_q, drop_cnt_d;
    logic                  run_q;
    logic [CNT_W-1:0]      buf_count, buf_pending, count_after_pop;
    logic [CNT_W:0]        occupancy;
    logic                  head_valid;
    logic [DATA_WIDTH-1:0] head_instr;
    logic [ADDR_WIDTH-1:0] head_pc;
    logic                  pop, accept, rsp_live, dropping, fill_en;
    logic                  unused_redirect_lsbs;

    assign unused_redirect_lsbs = ^redirect_pc[INSTR_ALIGN-1:0];

    // Stale requests still owed by memory reserve capacity just like live slots.
    assign pop             = head_valid & id_ready;
    assign count_after_pop = buf_count - CNT_W'(pop);
    assign occupancy       = {1'b0, count_after_pop} + {1'b0, drop_cnt_q};
    assign imem_req_valid  = run_q & ~redirect_valid & (occupancy < (CNT_W+1)'(DEPTH));
    assign imem_req_addr   = pc_q;
    assign accept          = imem_req_valid & imem_req_ready;

    assign rsp_live = imem_rsp_valid & ((drop_cnt_q != '0) | (buf_pending != '0));
    assign dropping = rsp_live & (drop_cnt_q != '0);
    assign fill_en  = rsp_live & (drop_cnt_q == '0);

    always_comb begin
        pc_d       = pc_q;
        drop_cnt_d = drop_cnt_q;
        if (redirect_valid) begin
            pc_d       = {redirect_pc[ADDR_WIDTH-1:INSTR_ALIGN], {INSTR_ALIGN{1'b0}}};
            drop_cnt_d = drop_cnt_q + buf_pending - CNT_W'(rsp_live);
        end else begin
            if (accept) begin
                pc_d = pc_q + ADDR_WIDTH'(4);
            end
            if (dropping) begin
                drop_cnt_d = drop_cnt_q - CNT_W'(1);
            end
        end
    end

    always_comb begin
        last_pc_d = last_pc_q;
        if (head_valid) begin
            last_pc_d = head_pc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q       <= RESET_PC;
            last_pc_q  <= '0;
            drop_cnt_q <= '0;
            run_q      <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            last_pc_q  <= last_pc_d;
            drop_cnt_q <= drop_cnt_d;
            run_q      <= 1'b1;
        end
    end

    fetch_buffer #(
        .DEPTH (DEPTH)
    ) u_buffer (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (redirect_valid),
        .alloc_en   (accept),
        .alloc_pc   (pc_q),
        .fill_en    (fill_en),
        .fill_instr (imem_rsp_data),
        .pop_en     (pop),
        .head_valid (head_valid),
        .head_instr (head_instr),
        .head_pc    (head_pc),
        .count      (buf_count),
        .pending    (buf_pending)
    );

    assign id_valid    = head_valid;
    assign id_instr    = head_valid ? head_instr : DATA_WIDTH'(NOP_INSTR);
    assign id_pc       = head_valid ? head_pc : last_pc_q;
    assign id_pc_plus4 = id_pc + ADDR_WIDTH'(4);

    rsp_has_owner: assert property (@(posedge clk) disable iff (!rst_n)
        imem_rsp_valid |-> ((drop_cnt_q != '0) || (buf_pending != '0)));

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - scoreboard bench for fetch_unit with randomized memory and redirects
module tb_fetch_unit;
    import riscv_pkg::*;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] KEY    = 32'hA5A5_0000;

    logic        clk;
    logic        rst_n;
    logic        imem_req_valid, imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_ready, id_valid;
    logic [31:0] id_instr, id_pc, id_pc_plus4;

    fetch_unit #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (32),
        .RESET_PC   (RST_PC),
        .DEPTH      (2)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_ready       (id_ready),
        .id_valid       (id_valid),
        .id_instr       (id_instr),
        .id_pc          (id_pc),
        .id_pc_plus4    (id_pc_plus4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          n_acc = 0;
    int          retired = 0;
    int          mem_lat = 1;
    int          last_due = 0;
    int          rdy_pct = 100;
    int          idr_pct = 100;
    logic [31:0] exp_req;
    logic [31:0] exp_q[$];
    logic [31:0] mem_addr_q[$];
    int          mem_due_q[$];
    logic [31:0] last_pc = 32'h0;
    logic [31:0] mon_e;

    function automatic void check(string name, logic [31:0] act, logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: actual %h required %h", name, act, req);
        end
    endfunction

    // Memory model, request scoreboard and expected-stream producer; returns at negedge+1.
    task automatic step(input logic redir, input logic [31:0] tgt);
        int due;
        @(negedge clk);
        cyc++;
        redirect_valid = redir;
        redirect_pc    = tgt;
        imem_req_ready = ($urandom_range(99) < rdy_pct);
        id_ready       = ($urandom_range(99) < idr_pct);
        if (mem_due_q.size() > 0 && mem_due_q[0] <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_addr_q[0] ^ KEY;
            void'(mem_due_q.pop_front());
            void'(mem_addr_q.pop_front());
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
        end
        if (redir) begin
            exp_q.delete();
            exp_q.push_back({tgt[31:2], 2'b00});
            exp_req = {tgt[31:2], 2'b00};
        end
        while (exp_q.size() < 4) exp_q.push_back(exp_q[$] + 32'd4);
        #1;
        if (redir) check("no_req_in_redirect", 32'(imem_req_valid), 32'd0);
        if (imem_req_valid && imem_req_ready) begin
            check("req_addr", imem_req_addr, exp_req);
            exp_req = exp_req + 32'd4;
            n_acc++;
            due = cyc + mem_lat;
            if (due < last_due) due = last_due;
            last_due = due;
            mem_addr_q.push_back(imem_req_addr);
            mem_due_q.push_back(due);
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 32'h0);
    endtask

    // Called at negedge+1; asserts reset between edges, with a stray response while held.
    task automatic apply_reset();
        #2;
        rst_n          = 1'b0;
        imem_rsp_valid = 1'b0;
        redirect_valid = 1'b0;
        #1;
        check("rst_id_valid", 32'(id_valid), 32'd0);
        check("rst_id_instr", id_instr, NOP_INSTR);
        check("rst_id_pc", id_pc, 32'h0);
        check("rst_req_valid", 32'(imem_req_valid), 32'd0);
        mem_addr_q.delete();
        mem_due_q.delete();
        exp_q.delete();
        exp_q.push_back(RST_PC);
        exp_req  = RST_PC;
        last_due = 0;
        n_acc    = 0;
        retired  = 0;
        @(negedge clk);
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hDEAD_BEEF;
        @(negedge clk);
        imem_rsp_valid = 1'b0;
        rst_n          = 1'b1;
    endtask

    // Retire monitor: pops the expected stream whenever decode takes an instruction.
    always @(negedge clk) begin
        #2;
        if (!rst_n) begin
            last_pc = 32'h0;
        end else if (id_valid) begin
            last_pc = id_pc;
            if (id_ready && !redirect_valid) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL retire_unexpected: actual %h required none", id_pc);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("id_pc", id_pc, mon_e);
                    check("id_instr", id_instr, mon_e ^ KEY);
                    check("id_pc_plus4", id_pc_plus4, mon_e + 32'd4);
                    retired++;
                end
            end
        end else begin
            check("idle_instr", id_instr, NOP_INSTR);
            check("idle_pc_hold", id_pc, last_pc);
        end
    end

    initial begin
        int acc0, ret0;
        logic seen;
        rst_n = 1'b1; imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
        redirect_valid = 1'b0; redirect_pc = '0; id_ready = 1'b1;
        exp_req = RST_PC;
        exp_q.push_back(RST_PC);

        // Throughput with single-cycle memory
        apply_reset();
        step(1'b0, 32'h0);
        check("first_req_valid", 32'(imem_req_valid), 32'd1);
        check("first_req_addr", imem_req_addr, RST_PC);
        #2;
        check("post_rst_no_instr", 32'(id_valid), 32'd0);
        step(1'b0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 32'h0);
            #2;
            check("tput_valid", 32'(id_valid), 32'd1);
            check("tput_pc", id_pc, 32'(4 * i));
        end
        run(5);

        // Decode stall for five cycles
        apply_reset();
        run(2);
        idr_pct = 0;
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 32'h0);
            #2;
            check("stall_valid", 32'(id_valid), 32'd1);
            check("stall_pc", id_pc, 32'h0);
            check("stall_inflight_le_depth", 32'(n_acc - retired <= 2), 32'd1);
        end
        idr_pct = 100;
        ret0 = retired;
        run(10);
        check("stall_release_progress", 32'(retired >= ret0 + 8), 32'd1);

        // Memory not ready for four cycles
        apply_reset();
        run(2);
        rdy_pct = 0;
        acc0 = n_acc;
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 32'h0);
            check("held_req_valid", 32'(imem_req_valid), 32'd1);
            check("held_req_addr", imem_req_addr, 32'h8);
        end
        check("held_no_accept", 32'(n_acc), 32'(acc0));
        rdy_pct = 100;
        step(1'b0, 32'h0);
        check("held_accept_once", 32'(n_acc), 32'(acc0 + 1));
        run(6);

        // Redirect with two requests in flight, latency 3
        apply_reset();
        mem_lat = 3;
        for (int i = 0; i < 10 && mem_addr_q.size() < 2; i++) step(1'b0, 32'h0);
        check("two_in_flight", 32'(mem_addr_q.size()), 32'd2);
        step(1'b1, 32'h0000_0103);
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            step(1'b0, 32'h0);
            #2;
            if (id_valid) begin
                seen = 1'b1;
                check("redir_first_pc", id_pc, 32'h100);
            end
        end
        check("redir_first_seen", 32'(seen), 32'd1);

        // Wrap of the PC at the top of the address space
        step(1'b1, 32'hFFFF_FFFE);
        mem_lat = 1;
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            step(1'b0, 32'h0);
            #2;
            if (id_valid) begin
                seen = 1'b1;
                check("wrap_pc", id_pc, 32'hFFFF_FFFC);
                check("wrap_plus4", id_pc_plus4, 32'h0);
            end
        end
        check("wrap_seen", 32'(seen), 32'd1);
        run(4);

        // Reset mid-burst with a response pending
        mem_lat = 2;
        run(3);
        check("pending_before_reset", 32'(mem_addr_q.size() > 0), 32'd1);
        apply_reset();
        step(1'b0, 32'h0);
        check("reset_burst_req_addr", imem_req_addr, RST_PC);
        #2;
        check("reset_burst_no_late", 32'(id_valid), 32'd0);

        // Randomized traffic
        rdy_pct = 70;
        idr_pct = 70;
        ret0 = retired;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(99) == 0) mem_lat = $urandom_range(1, 4);
            step($urandom_range(99) < 3, $urandom);
        end
        rdy_pct = 100;
        idr_pct = 100;
        run(30);
        check("random_progress", 32'(retired - ret0 > 500), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage of the RISC-V core, directly upstream of decode (decoder + immediate extension).
- Owns the PC and issues in-order word requests to instruction memory over a valid/ready request channel.
- Holds returned words with their PCs in a small in-order slot buffer and presents one instruction per cycle to decode.
- Handles decode stalls (id_ready) and control-flow redirects from execute; responses that were in flight at a redirect are discarded.

Parameters:
- DATA_WIDTH, 32, instruction word width.
- ADDR_WIDTH, 32, PC / memory address width.
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- DEPTH, 2, slots in the fetch buffer; also the maximum number of outstanding requests.

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- imem_req_valid  out  1  request to instruction memory.
- imem_req_ready  in  1  memory accepts the request this cycle.
- imem_req_addr  out  ADDR_WIDTH  word address, bits[1:0] always 00.
- imem_rsp_valid  in  1  response word valid; responses are in order, at least 1 cycle after acceptance.
- imem_rsp_data  in  DATA_WIDTH  instruction word.
- redirect_valid  in  1  branch/jump taken or flush from execute.
- redirect_pc  in  ADDR_WIDTH  new fetch target; bits[1:0] ignored (treated as 00).
- id_ready  in  1  decode can accept; low means stall.
- id_valid  out  1  id_instr / id_pc are valid.
- id_instr  out  DATA_WIDTH  instruction to decode.
- id_pc  out  ADDR_WIDTH  PC of id_instr.
- id_pc_plus4  out  ADDR_WIDTH  id_pc + 4, wraps modulo 2^ADDR_WIDTH.

Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.

Behaviour:
- Reset (async assert, any state including mid-transaction):
  - pc = RESET_PC; all slots empty; alloc/fill/read pointers = 0; drop_cnt = 0.
  - imem_req_valid = 0, id_valid = 0, id_instr = 32'h0000_0013 (NOP), id_pc = 0.
- First request:
  - imem_req_valid rises in the first cycle after rst_n deasserts, with imem_req_addr = RESET_PC.
- Slots:
  - Each slot holds {pc, instr, filled}.
  - alloc pointer: advances on request accept; stores the request PC; filled = 0.
  - fill pointer: advances on imem_rsp_valid when drop_cnt = 0; writes instr; filled = 1.
  - read pointer: advances on pop.
  - Pointers are mod-DEPTH with an occupancy count (0..DEPTH).
- Issue:
  - imem_req_valid = (count_after_pop < DEPTH) and !redirect_valid, where count_after_pop credits a pop in the same cycle.
  - On accept, pc += 4 (wraps).
  - imem_req_valid/addr are held stable while ready is low, unless a redirect occurs.
- Output:
  - id_valid = head slot filled; id_instr/id_pc come from the head slot.
  - When id_valid = 0, id_instr = NOP and id_pc holds its last value.
- Pop:
  - Occurs when id_valid & id_ready.
  - Pop, fill and alloc may all occur in the same cycle.
  - With single-cycle memory and id_ready held high, throughput is 1 instruction/cycle.
- Full: count == DEPTH means no request.
- Empty: count == 0 means id_valid = 0.
- Redirect (highest priority):
  - Next cycle: pc = {redirect_pc[31:2],2'b00}; all slots cleared; pointers = 0.
  - drop_cnt = number of allocated-but-unfilled slots, excluding any response arriving this cycle.
  - No request is issued in the redirect cycle.
  - A same-cycle pop is irrelevant because decode is flushed too.
  - First request to the target is issued the cycle after the redirect.
- Drop:
  - While drop_cnt > 0, each imem_rsp_valid decrements drop_cnt and its data is discarded.
  - Issue may resume during drop; the occupancy check uses count + drop_cnt < DEPTH.
- Back-to-back redirects: the latest one wins; drop_cnt accumulates outstanding requests correctly.
- Error check: imem_rsp_valid with no outstanding request is illegal (simulation assertion).

Decomposition:
- Shared riscv_pkg:
  - NOP_INSTR = 32'h0000_0013; INSTR_ALIGN = 2.
  - fetch_slot_t struct {pc, instr, filled}.
- Sub-module fetch_buffer:
  - DEPTH-slot in-order alloc/fill/read buffer with count and flush input.
  - fetch_unit keeps the PC, issue logic and drop counter.

Test Plan:
- Reset then id_ready=1, 1-cycle memory returning addr^32'hA5A5_0000 -> requests to 0x0, 0x4, 0x8 on consecutive cycles; id_pc 0x0, 0x4, 0x8 on consecutive cycles, each with id_instr = addr^0xA5A50000 and id_pc_plus4 = id_pc + 4.
- id_ready=0 for 5 cycles after the first fill -> at most 2 requests outstanding/held; id_valid stays 1 with id_pc=0x0 held; after release, 0x0 and 0x4 retire in order with no loss or duplication.
- Redirect to 0x0000_0103 while 2 requests are in flight (memory latency 3) -> both stale responses dropped; next request addr 0x100; first id_pc=0x100.
- imem_req_ready=0 for 4 cycles -> imem_req_addr is stable at 0x8 and pc does not advance; on ready, 0x8 is accepted exactly once.
- pc = 32'hFFFF_FFFC fetched -> id_pc_plus4 = 0x0; next request addr = 0x0.
- Assert rst_n low mid-burst with a response pending -> id_valid=0 and id_instr=NOP immediately; after release, first request is RESET_PC; late responses are not accepted before the new request.
